// File: rtl/uart_apb_seq_if.sv
// uart_apb_seq_if: groups every non-clock/reset signal of the UART APB
// sequencer so the sequencer and its environment connect through one bundle.
//   master modport : the sequencer side (drives APB, TX ready, RX stream)
//   slave modport  : the environment side (UART APB slave, byte producer/consumer)
// Signals:
//   cfg_start_i/cfg_word_i   config write request and value
//   run_i                    enables polling and data transfers
//   tx_valid_i/tx_data_i/tx_ready_o   TX byte stream
//   rx_valid_o/rx_data_o/rx_ready_i   RX byte stream
//   paddr_o/pwdata_o/psel_o/penable_o/pwrite_o/prdata_i   APB master port
//   cfg_done_o/busy_o        status
interface uart_apb_seq_if;
  logic        cfg_start_i;
  logic [31:0] cfg_word_i;
  logic        run_i;
  logic        tx_valid_i;
  logic [7:0]  tx_data_i;
  logic        tx_ready_o;
  logic        rx_valid_o;
  logic [7:0]  rx_data_o;
  logic        rx_ready_i;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] prdata_i;
  logic        cfg_done_o;
  logic        busy_o;

  modport master (
    input  cfg_start_i, cfg_word_i, run_i, tx_valid_i, tx_data_i,
           rx_ready_i, prdata_i,
    output tx_ready_o, rx_valid_o, rx_data_o, paddr_o, pwdata_o,
           psel_o, penable_o, pwrite_o, cfg_done_o, busy_o
  );

  modport slave (
    output cfg_start_i, cfg_word_i, run_i, tx_valid_i, tx_data_i,
           rx_ready_i, prdata_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, paddr_o, pwdata_o,
           psel_o, penable_o, pwrite_o, cfg_done_o, busy_o
  );
endinterface

// File: rtl/uart_apb_seq.sv
// uart_apb_seq: APB master sequencer owning the UART APB slave port. Writes
// the UART config register on request, then polls the status register and
// schedules TX-data writes / RX-data reads between two byte streams.
// Ports:
//   clk   system clock, rising edge
//   rst_  asynchronous active-low reset
//   bus   uart_apb_seq_if.master (config request, run, TX/RX streams, APB)
// Build option:
//   UART_SEQ_RR_EN  defined -> round-robin TX/RX arbitration on ties;
//                   undefined -> RX always wins ties (no pointer register).
// All outputs are registered; next values are derived from the next state.
module uart_apb_seq (
  input  logic           clk,
  input  logic           rst_,
  uart_apb_seq_if.master bus
);

  localparam logic [31:0] ADDR_CFG    = 32'h0000_0000;
  localparam logic [31:0] ADDR_STAT   = 32'h0000_0004;
  localparam logic [31:0] ADDR_TXD    = 32'h0000_0008;
  localparam logic [31:0] ADDR_RXD    = 32'h0000_000C;
  localparam int unsigned TXFULL_BIT  = 0;
  localparam int unsigned RXEMPTY_BIT = 1;

  typedef enum logic [3:0] {
    IDLE,
    CFG_SETUP,
    CFG_ACC,
    POLL_SETUP,
    POLL_ACC,
    TX_SETUP,
    TX_ACC,
    RX_SETUP,
    RX_ACC
  } state_t;

  state_t      state;
  state_t      state_nx;
  state_t      dec_state;

  logic        cfg_pend;
  logic [31:0] cfg_word;
  logic        cfg_done;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        tx_elig;
  logic        rx_elig;
  logic        tie_tx;

  logic [31:0] paddr,   paddr_nx;
  logic [31:0] pwdata,  pwdata_nx;
  logic        psel,    psel_nx;
  logic        penable, penable_nx;
  logic        pwrite,  pwrite_nx;
  logic        tx_ready, tx_ready_nx;
  logic        busy,    busy_nx;

  // Only the low byte and the two status flags of the read data matter.
  logic        unused_prdata;
  assign unused_prdata = ^bus.prdata_i[31:8];

  // Tie-break between TX and RX when both are eligible after a poll.
`ifdef UART_SEQ_RR_EN
  logic tx_first;
  assign tie_tx = tx_first;
`else
  assign tie_tx = 1'b0;
`endif

  // Eligibility is only meaningful while the status read is in its access
  // cycle; run_i gating lets a dropped run finish the poll and go idle.
  assign tx_elig = bus.run_i && bus.tx_valid_i && !bus.prdata_i[TXFULL_BIT];
  assign rx_elig = bus.run_i && !bus.prdata_i[RXEMPTY_BIT] && !rx_valid;

  // Common decision point: pending config first, then polling, else idle.
  always_comb begin
    dec_state = IDLE;
    if (cfg_pend) begin
      dec_state = CFG_SETUP;
    end else if (bus.run_i && cfg_done) begin
      dec_state = POLL_SETUP;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = dec_state;
      CFG_SETUP:  state_nx = CFG_ACC;
      CFG_ACC:    state_nx = dec_state;
      POLL_SETUP: state_nx = POLL_ACC;
      POLL_ACC: begin
        if (cfg_pend) begin
          state_nx = CFG_SETUP;
        end else if (tx_elig && rx_elig) begin
          state_nx = tie_tx ? TX_SETUP : RX_SETUP;
        end else if (rx_elig) begin
          state_nx = RX_SETUP;
        end else if (tx_elig) begin
          state_nx = TX_SETUP;
        end else begin
          state_nx = dec_state;
        end
      end
      TX_SETUP:   state_nx = TX_ACC;
      TX_ACC:     state_nx = dec_state;
      RX_SETUP:   state_nx = RX_ACC;
      RX_ACC:     state_nx = dec_state;
      default:    state_nx = IDLE;
    endcase
  end

  // Next APB/handshake outputs; address, data and direction are captured on
  // entry to a SETUP state and held through the following ACC state.
  always_comb begin
    paddr_nx    = paddr;
    pwdata_nx   = pwdata;
    pwrite_nx   = pwrite;
    psel_nx     = (state_nx != IDLE);
    penable_nx  = 1'b0;
    tx_ready_nx = (state_nx == TX_ACC);
    busy_nx     = (state_nx != IDLE);
    case (state_nx)
      IDLE: begin
        paddr_nx  = 32'h0;
        pwdata_nx = 32'h0;
        pwrite_nx = 1'b0;
      end
      CFG_SETUP: begin
        paddr_nx  = ADDR_CFG;
        pwdata_nx = cfg_word;
        pwrite_nx = 1'b1;
      end
      POLL_SETUP: begin
        paddr_nx  = ADDR_STAT;
        pwdata_nx = 32'h0;
        pwrite_nx = 1'b0;
      end
      TX_SETUP: begin
        paddr_nx  = ADDR_TXD;
        pwdata_nx = {24'h0, bus.tx_data_i};
        pwrite_nx = 1'b1;
      end
      RX_SETUP: begin
        paddr_nx  = ADDR_RXD;
        pwdata_nx = 32'h0;
        pwrite_nx = 1'b0;
      end
      CFG_ACC, POLL_ACC, TX_ACC, RX_ACC: begin
        penable_nx = 1'b1;
      end
      default: begin
        penable_nx = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      paddr    <= 32'h0;
      pwdata   <= 32'h0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      paddr    <= paddr_nx;
      pwdata   <= pwdata_nx;
      psel     <= psel_nx;
      penable  <= penable_nx;
      pwrite   <= pwrite_nx;
      tx_ready <= tx_ready_nx;
      busy     <= busy_nx;
    end
  end

  // Config request latch: a new start always wins over the service clear so
  // a start arriving while a config write is launched is not lost.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cfg_pend <= 1'b0;
      cfg_word <= 32'h0;
      cfg_done <= 1'b0;
    end else begin
      if (bus.cfg_start_i) begin
        cfg_pend <= 1'b1;
        cfg_word <= bus.cfg_word_i;
      end else if (state_nx == CFG_SETUP) begin
        cfg_pend <= 1'b0;
      end
      if (state == CFG_ACC) begin
        cfg_done <= 1'b1;
      end
    end
  end

  // RX holding register: loaded at the end of the RXD read, drained by the
  // consumer handshake. A poll never grants RX while it is occupied.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h0;
    end else if (state == RX_ACC) begin
      rx_valid <= 1'b1;
      rx_data  <= bus.prdata_i[7:0];
    end else if (rx_valid && bus.rx_ready_i) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef UART_SEQ_RR_EN
  // Round-robin pointer: the direction just granted loses the next tie.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tx_first <= 1'b0;
    end else if (state == POLL_ACC) begin
      if (state_nx == RX_SETUP) begin
        tx_first <= 1'b1;
      end else if (state_nx == TX_SETUP) begin
        tx_first <= 1'b0;
      end
    end
  end
`endif

  assign bus.paddr_o    = paddr;
  assign bus.pwdata_o   = pwdata;
  assign bus.psel_o     = psel;
  assign bus.penable_o  = penable;
  assign bus.pwrite_o   = pwrite;
  assign bus.tx_ready_o = tx_ready;
  assign bus.rx_valid_o = rx_valid;
  assign bus.rx_data_o  = rx_data;
  assign bus.cfg_done_o = cfg_done;
  assign bus.busy_o     = busy;

endmodule
